// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe : two-stage pipelined ALU with valid/ready handshakes.
//   Stage 1 captures a, b and cmd on accept.
//   Stage 2 computes the result, flags and the illegal-opcode error.
// Both stages advance together whenever the output register is empty or is
// being consumed, so a stalled result freezes the whole pipeline.
// Optional feature: define ALU_PIPE_SAT_EN to saturate ADD/SUB overflow to
// the signed max/min instead of wrapping (flag_v is reported either way).
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       cmd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic             err
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_NOR = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SRA = 4'd6;
    localparam logic [3:0] OP_ROR = 4'd7;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             advance;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_cmd;

    logic [WIDTH-1:0] c_result;
    logic             c_z;
    logic             c_v;
    logic             c_n;
    logic             c_err;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;

    // Stage 1: capture the request operands whenever the pipeline advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cmd   <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= a;
                s1_b   <= b;
                s1_cmd <= cmd;
            end
        end
    end

    // Combinational ALU on the stage-1 contents; rotate uses the negated
    // amount modulo WIDTH so a zero rotate leaves the operand unchanged
    always_comb begin
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] diff;
        logic [SW-1:0]    sh;
        logic [SW-1:0]    neg_sh;
        logic             ovf;

        sum      = s1_a + s1_b;
        diff     = s1_a - s1_b;
        sh       = s1_b[SW-1:0];
        neg_sh   = -sh;
        ovf      = 1'b0;
        c_result = '0;
        c_v      = 1'b0;
        c_err    = 1'b0;

        case (s1_cmd)
            OP_ADD: begin
                ovf      = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
                c_result = sum;
                c_v      = ovf;
            end
            OP_SUB: begin
                ovf      = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
                c_result = diff;
                c_v      = ovf;
            end
            OP_AND: c_result = s1_a & s1_b;
            OP_NOR: c_result = ~(s1_a | s1_b);
            OP_SLL: c_result = s1_a << sh;
            OP_SRL: c_result = s1_a >> sh;
            OP_SRA: c_result = $unsigned($signed(s1_a) >>> sh);
            OP_ROR: c_result = (s1_a >> sh) | (s1_a << neg_sh);
            default: c_err   = 1'b1;
        endcase

`ifdef ALU_PIPE_SAT_EN
        if (ovf) begin
            c_result = s1_a[WIDTH-1] ? SMIN : SMAX;
        end
`endif

        c_z = !c_err && (c_result == '0);
        c_n = !c_err && c_result[WIDTH-1];
    end

    // Stage 2: register result and flags; holds while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_v    <= 1'b0;
            flag_n    <= 1'b0;
            err       <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= c_result;
                flag_z <= c_z;
                flag_v <= c_v;
                flag_n <= c_n;
                err    <= c_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe : scoreboard bench for alu_pipe at WIDTH=16.
// Directed vectors push their hand-computed response into a queue when the
// DUT accepts them; a negedge monitor pops and compares on every consumed
// result, and also checks reset outputs and stall stability.
// Expected ADD/SUB overflow values follow ALU_PIPE_SAT_EN when defined.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        v;
        logic        n;
        logic        e;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  cmd;
        logic [15:0] res;
        logic        z;
        logic        v;
        logic        n;
        logic        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [3:0]  cmd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic        err;

    int   checks = 0;
    int   failures = 0;
    bit   monOn = 1'b0;
    exp_t sb[$];

    bit          holdValid = 1'b0;
    logic [15:0] holdRes;
    logic [3:0]  holdFlags;

    vec_t vecs[17];

    alu_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cmd       (cmd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .flag_n    (flag_n),
        .err       (err)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one request, wait (bounded) for acceptance, push its expectation
    task automatic applyStimulus(input vec_t v, output int waits);
        exp_t e;
        bit   done;
        waits = 0;
        done  = 1'b0;
        a = v.a;
        b = v.b;
        cmd = v.cmd;
        in_valid = 1'b1;
        while (!done && waits < 50) begin
            @(negedge clk);
            if (in_ready) begin
                e.res = v.res; e.z = v.z; e.v = v.v; e.n = v.n; e.e = v.e;
                sb.push_back(e);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=no_accept expected=accept cmd=%0d", v.cmd);
        end
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected result has been consumed
    task automatic waitDrain();
        int n;
        n = 0;
        while (!(sb.size() == 0 && !out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d_pending expected=0_pending", sb.size());
        end
    endtask

    // Monitor: reset values, stall stability, and scoreboard comparison
    always @(negedge clk) begin
        exp_t e;
        if (monOn) begin
            if (rst) begin
                checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
                checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
                checkOutput("rst_result", {16'd0, result}, 32'd0);
                checkOutput("rst_flags_err", {28'd0, flag_z, flag_v, flag_n, err}, 32'd0);
                holdValid = 1'b0;
            end else begin
                if (holdValid) begin
                    checkOutput("stall_hold_valid", {31'd0, out_valid}, 32'd1);
                    checkOutput("stall_hold_result", {16'd0, result}, {16'd0, holdRes});
                    checkOutput("stall_hold_flags", {28'd0, flag_z, flag_v, flag_n, err}, {28'd0, holdFlags});
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_output actual=0x%0h expected=no_output", result);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("result", {16'd0, result}, {16'd0, e.res});
                        checkOutput("flags_zvn_err", {28'd0, flag_z, flag_v, flag_n, err},
                                    {28'd0, e.z, e.v, e.n, e.e});
                    end
                end
                if (out_valid && !out_ready) begin
                    checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    holdValid = 1'b1;
                    holdRes   = result;
                    holdFlags = {flag_z, flag_v, flag_n, err};
                end else begin
                    holdValid = 1'b0;
                end
            end
        end
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence
    initial begin
        int   w;
        vec_t v;

`ifdef ALU_PIPE_SAT_EN
        vecs[0]  = '{16'h7FFF, 16'h0001, 4'd0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{16'h8000, 16'h0001, 4'd1, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{16'h8000, 16'h8000, 4'd0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        vecs[0]  = '{16'h7FFF, 16'h0001, 4'd0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{16'h8000, 16'h0001, 4'd1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{16'h8000, 16'h8000, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
        vecs[2]  = '{16'h0001, 16'h0002, 4'd0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'hFFFF, 16'h0001, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{16'hF0F0, 16'hFF00, 4'd2, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{16'h0000, 16'h0000, 4'd3, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{16'h1234, 16'h0000, 4'd4, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h00F1, 16'h0014, 4'd4, 16'h0F10, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{16'h8000, 16'h0004, 4'd5, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'h8000, 16'h000F, 4'd6, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{16'h0001, 16'h0001, 4'd7, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{16'h1234, 16'h0000, 4'd7, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{16'h7000, 16'h0004, 4'd6, 16'h0700, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{16'h1234, 16'h5678, 4'hC, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{16'hFFFF, 16'hFFFF, 4'hF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{16'hF0F0, 16'h0F0F, 4'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset phase: monitor checks outputs while rst is high
        #2 rst = 1'b1;
        monOn = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // All directed vectors, issued back to back
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i], w);
            checkOutput("no_stall_accept", w, 32'd0);
        end
        waitDrain();

        // SUB 5-5 on an idle pipe: accept edge plus one more edge to output
        @(posedge clk);
        #1;
        v = '{16'h0005, 16'h0005, 4'd1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        applyStimulus(v, w);
        checkOutput("latency_after_accept_edge", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("latency_after_second_edge", {31'd0, out_valid}, 32'd1);
        waitDrain();

        // Stream 4 ADDs while the consumer stalls for 5 cycles
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 1; i <= 4; i++) begin
                    v = '{16'(i), 16'(i), 4'd0, 16'(2 * i), 1'b0, 1'b0, 1'b0, 1'b0};
                    applyStimulus(v, w);
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain();

        // Reset with two ops in flight: both discarded, new op follows cleanly
        @(posedge clk);
        #1;
        v = '{16'h0100, 16'h0001, 4'd0, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0};
        applyStimulus(v, w);
        v = '{16'h0200, 16'h0002, 4'd0, 16'h0202, 1'b0, 1'b0, 1'b0, 1'b0};
        applyStimulus(v, w);
        rst = 1'b1;
        #1;
        checkOutput("rst_flush_out_valid", {31'd0, out_valid}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        v = '{16'h0003, 16'h0004, 4'd1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        applyStimulus(v, w);
        checkOutput("post_rst_first_accept", w, 32'd0);
        checkOutput("post_rst_latency_edge1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("post_rst_latency_edge2", {31'd0, out_valid}, 32'd1);
        waitDrain();
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; SHALL be a power of two in the range 4..64.
REQ-002 Derived parameter SW, default 4 (clog2(WIDTH)), shift-amount width.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B; b[SW-1:0] is the shift/rotate amount.
REQ-009 cmd  input  4  opcode.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 flag_z, flag_v, flag_n  output  1 each  zero, signed overflow, negative.
REQ-014 err  output  1  illegal opcode for the presented result.

Function
REQ-015 Opcodes SHALL be: 0 ADD a+b, 1 SUB a-b, 2 AND, 3 NOR, 4 SLL, 5 SRL, 6 SRA, 7 ROR (rotate right).
REQ-016 Opcodes 8..15 SHALL produce result 0, err=1, all flags 0.
REQ-017 Pipeline: stage 1 registers a, b, cmd; stage 2 computes and registers result, flags, err.
REQ-018 A request is accepted on a rising edge where in_valid && in_ready.
REQ-019 A result is consumed on a rising edge where out_valid && out_ready.
REQ-020 advance = !out_valid || out_ready; in_ready SHALL equal advance when rst is low; both stages SHALL shift only when advance is 1.
REQ-021 Latency: an accepted request SHALL appear on out_valid/result two rising edges after its accept edge, with no backpressure.
REQ-022 Throughput: one op per cycle with out_ready held 1; no bubbles inserted.
REQ-023 While out_valid && !out_ready, result, flags, err and stage-1 contents SHALL hold stable.
REQ-024 Simultaneous consume and accept on the same edge SHALL be legal and lose no data.
REQ-025 flag_z = (result == 0); flag_n = result[WIDTH-1].
REQ-026 flag_v = two's-complement overflow for ADD/SUB only; 0 for all other opcodes.
REQ-027 ADD/SUB carry-out SHALL be discarded; arithmetic is modulo 2^WIDTH unless REQ-033 applies.
REQ-028 Shift amount 0 SHALL return a unchanged for opcodes 4..7; SRA SHALL replicate a[WIDTH-1].
REQ-029 Bubbles (in_valid low on an accept-eligible edge) SHALL propagate as out_valid=0.

Reset
REQ-030 While rst is high: out_valid=0, in_ready=0, result=0, flag_z=flag_v=flag_n=0, err=0, stage-1 valid=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight ops; none reappear after release.
REQ-032 First accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-033 Macro ALU_PIPE_SAT_EN defined: ADD/SUB overflow SHALL saturate to 0x7FFF (positive overflow) or 0x8000 (negative overflow) at WIDTH=16 (generally max/min signed), with flag_v=1.
REQ-034 Macro ALU_PIPE_SAT_EN undefined: ADD/SUB SHALL wrap modulo 2^WIDTH, flag_v still reported.

Verification (WIDTH=16)
REQ-035 ADD a=0x7FFF b=0x0001 -> with SAT_EN result=0x7FFF v=1 n=0; without, result=0x8000 v=1 n=1.
REQ-036 SUB a=0x0005 b=0x0005 -> result=0x0000 z=1 v=0 n=0, out_valid exactly 2 edges after accept.
REQ-037 SRA a=0x8000 b=0x000F -> 0xFFFF n=1; ROR a=0x0001 b=0x0001 -> 0x8000; SLL b=0 -> a unchanged.
REQ-038 Stream 4 ADDs with out_ready=0 from cycle 3 for 5 cycles -> in_ready=0 during stall, result stable, all 4 results delivered in order, none lost or duplicated.
REQ-039 cmd=0xC a=0x1234 -> result=0x0000 err=1 flags 0.
REQ-040 Assert rst with two ops in flight -> out_valid=0 immediately; after release no stale result appears; new op completes with 2-edge latency.
